// File: rtl/timer_pwm_multi_if.sv
// Register bus shared with the legacy timer: write data/strobe, address, read enable, read data.
interface timer_pwm_multi_if;
  logic [31:0] d_in;
  logic [3:0]  addr;
  logic        ld;
  logic        oe;
  logic [31:0] d_out;

  modport master (output d_in, addr, ld, oe, input d_out);
  modport slave  (input d_in, addr, ld, oe, output d_out);
endinterface

// File: rtl/timer_pwm_multi.sv
// Multi-channel PWM timer: prescaled up or up/down counter, shadowed TOP/CMPn,
// per-channel PWM output and sticky match flag, overflow flag, register bus.
module timer_pwm_multi #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int PS_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  timer_pwm_multi_if.slave    bus,
  input  logic                ext_in,
  output logic [NCH-1:0]      pwm,
  output logic                overflow_interrupt,
  output logic                match_interrupt
);
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic                       en_q, mode_q, clksel_q, ovf_ie_q;
  logic [NCH-1:0]             mie_q, pol_q, match_flags;
  logic [PS_W-1:0]            presc_q, psc_q, psc_d;
  logic [WIDTH-1:0]           top_buf_q, top_buf_d, top_act_q, top_act_d;
  logic [WIDTH-1:0]           cnt_q, cnt_d;
  dir_e                       dir_q, dir_d;
  logic                       ovf_q, ovf_d, ovf_set, upd, match_tick;
  logic [2:0]                 ext_q;
  logic                       src_tick, cnt_tick;
  logic                       wr_ctrl, wr_top, wr_presc, wr_cnt, wr_stat;
  logic [NCH-1:0][WIDTH-1:0]  cmp_buf;
  logic [31:0]                rd;

  assign wr_ctrl  = bus.ld && (bus.addr == 4'd0);
  assign wr_top   = bus.ld && (bus.addr == 4'd1);
  assign wr_presc = bus.ld && (bus.addr == 4'd2);
  assign wr_cnt   = bus.ld && (bus.addr == 4'd3);
  assign wr_stat  = bus.ld && (bus.addr == 4'd4);

  // ext_q[1:0] is the synchroniser, ext_q[2] the edge-detect history
  assign src_tick = clksel_q ? (ext_q[1] & ~ext_q[2]) : 1'b1;
  assign cnt_tick = en_q & src_tick & (psc_q >= presc_q);

  // Prescaler next state; a COUNT write restarts the division
  always_comb begin
    psc_d = psc_q;
    if (wr_cnt)
      psc_d = '0;
    else if (en_q && src_tick)
      psc_d = (psc_q >= presc_q) ? '0 : psc_q + PS_W'(1);
  end

  // Counter/direction next state, overflow and update events
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    ovf_set    = 1'b0;
    upd        = 1'b0;
    match_tick = 1'b0;
    if (wr_cnt) begin
      // the bus write beats a coincident tick, so no flags from it
      cnt_d = bus.d_in[WIDTH-1:0];
      if (mode_q && (bus.d_in[WIDTH-1:0] >= top_act_q)) dir_d = DIR_DOWN;
    end else if (cnt_tick) begin
      match_tick = 1'b1;
      if (top_act_q == '0) begin
        cnt_d   = '0;
        ovf_set = 1'b1;
        upd     = 1'b1;
      end else if (!mode_q) begin
        if (cnt_q >= top_act_q) begin
          cnt_d   = '0;
          ovf_set = 1'b1;
          upd     = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else if ((dir_q == DIR_UP || cnt_q == '0) && (cnt_q < top_act_q)) begin
        // turn around as soon as TOP is reached so TOP is visited once
        cnt_d = cnt_q + WIDTH'(1);
        dir_d = (cnt_q + WIDTH'(1) == top_act_q) ? DIR_DOWN : DIR_UP;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
        dir_d = DIR_DOWN;
        if (cnt_q == WIDTH'(1)) begin
          dir_d   = DIR_UP;
          ovf_set = 1'b1;
          upd     = 1'b1;
        end
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
      psc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      psc_q <= psc_d;
    end
  end

  // TOP shadow (active follows buffer while stopped) and sticky OVF with set priority
  always_comb begin
    top_buf_d = wr_top ? bus.d_in[WIDTH-1:0] : top_buf_q;
    top_act_d = !en_q ? top_buf_d : (upd ? top_buf_q : top_act_q);
    ovf_d     = (ovf_q & ~(wr_stat & bus.d_in[0])) | ovf_set;
  end

  // Control/config registers, TOP, OVF flag, ext_in synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      clksel_q  <= 1'b0;
      ovf_ie_q  <= 1'b0;
      mie_q     <= '0;
      pol_q     <= '0;
      presc_q   <= '0;
      top_buf_q <= '0;
      top_act_q <= '0;
      ovf_q     <= 1'b0;
      ext_q     <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q     <= bus.d_in[0];
        mode_q   <= bus.d_in[1];
        clksel_q <= bus.d_in[2];
        ovf_ie_q <= bus.d_in[3];
        mie_q    <= bus.d_in[4 +: NCH];
        pol_q    <= bus.d_in[8 +: NCH];
      end
      if (wr_presc) presc_q <= bus.d_in[PS_W-1:0];
      top_buf_q <= top_buf_d;
      top_act_q <= top_act_d;
      ovf_q     <= ovf_d;
      ext_q     <= {ext_q[1:0], ext_in};
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] buf_q, buf_d, act_q, act_d;
    logic             pwm_q, pwm_d, flag_q, flag_d, wr_cmp, clr;

    assign wr_cmp = bus.ld && (bus.addr == 4'(5 + i));
    assign clr    = wr_stat && bus.d_in[1 + i];

    // Compare shadow, registered PWM level (frozen while stopped), sticky match flag
    always_comb begin
      buf_d  = wr_cmp ? bus.d_in[WIDTH-1:0] : buf_q;
      act_d  = !en_q ? buf_d : (upd ? buf_q : act_q);
      pwm_d  = en_q ? ((cnt_q < act_q) ^ pol_q[i]) : pwm_q;
      flag_d = (flag_q && !clr) || (match_tick && (cnt_d == act_q));
    end

    // Per-channel state
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        buf_q  <= '0;
        act_q  <= '0;
        pwm_q  <= 1'b0;
        flag_q <= 1'b0;
      end else begin
        buf_q  <= buf_d;
        act_q  <= act_d;
        pwm_q  <= pwm_d;
        flag_q <= flag_d;
      end
    end

    assign cmp_buf[i]     = buf_q;
    assign pwm[i]         = pwm_q;
    assign match_flags[i] = flag_q;
  end

  assign overflow_interrupt = ovf_q & ovf_ie_q;
  assign match_interrupt    = |(match_flags & mie_q);

  // Read mux; unimplemented bits and addresses read as zero
  always_comb begin
    rd = '0;
    case (bus.addr)
      4'd0: begin
        rd[0]          = en_q;
        rd[1]          = mode_q;
        rd[2]          = clksel_q;
        rd[3]          = ovf_ie_q;
        rd[4 +: NCH]   = mie_q;
        rd[8 +: NCH]   = pol_q;
      end
      4'd1: rd[WIDTH-1:0] = top_buf_q;
      4'd2: rd[PS_W-1:0]  = presc_q;
      4'd3: rd[WIDTH-1:0] = cnt_q;
      4'd4: begin
        rd[0]        = ovf_q;
        rd[1 +: NCH] = match_flags;
      end
      default: begin
        for (int i = 0; i < NCH; i++)
          if (bus.addr == 4'(5 + i)) rd[WIDTH-1:0] = cmp_buf[i];
      end
    endcase
  end

  assign bus.d_out = bus.oe ? rd : 32'd0;
endmodule

// File: tb/tb_timer_pwm_multi.sv
// Directed bench for timer_pwm_multi: up, up/down, prescaler, shadowing,
// compare boundaries, W1C collision, ext_in source and async reset.
module tb_timer_pwm_multi;
  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ext_in = 1'b0;
  logic [NCH-1:0] pwm;
  logic           ovf_irq, match_irq;
  int             nchk = 0;
  int             nerr = 0;

  timer_pwm_multi_if bus();

  timer_pwm_multi #(.WIDTH(32), .NCH(NCH), .PS_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .ext_in             (ext_in),
    .pwm                (pwm),
    .overflow_interrupt (ovf_irq),
    .match_interrupt    (match_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    bus.addr = a;
    bus.oe   = 1'b1;
    #1;
    v = bus.d_out;
    bus.oe = 1'b0;
  endtask

  // write captured on the posedge between the two negedges
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.d_in = d;
    bus.ld   = 1'b1;
    @(negedge clk);
    bus.ld   = 1'b0;
  endtask

  task automatic halt();
    wr(4'd0, 32'h0);
    wr(4'd3, 32'h0);
    wr(4'd4, 32'h1F);
  endtask

  initial begin
    logic [31:0] v;
    int          m, pc;
    bus.d_in = '0;
    bus.addr = '0;
    bus.ld   = 1'b0;
    bus.oe   = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst pwm", 32'(pwm), 32'h0);
    rst = 1'b1;
    for (int a = 0; a < 9; a++) begin
      rd(4'(a), v);
      chk($sformatf("rst reg%0d", a), v, 32'h0);
    end
    chk("rst irqs", {30'b0, ovf_irq, match_irq}, 32'h0);

    // up mode, TOP=9, CMP0=3, OVF_IE + MATCH_IE0
    wr(4'd1, 32'd9);
    wr(4'd5, 32'd3);
    wr(4'd0, 32'h19);
    for (int k = 0; k < 12; k++) begin
      rd(4'd3, v);
      chk($sformatf("up cnt k%0d", k), v, 32'(k % 10));
      chk($sformatf("up pwm0 k%0d", k), 32'(pwm[0]), 32'((k >= 1) && (((k - 1) % 10) < 3)));
      chk($sformatf("up ovf_irq k%0d", k), 32'(ovf_irq), 32'(k >= 10));
      chk($sformatf("up match_irq k%0d", k), 32'(match_irq), 32'(k >= 3));
      @(negedge clk);
    end

    // prescaler 3 (divide by 4), TOP=4
    halt();
    wr(4'd1, 32'd4);
    wr(4'd2, 32'd3);
    wr(4'd0, 32'h1);
    for (int k = 0; k < 22; k++) begin
      rd(4'd3, v);
      chk($sformatf("psc cnt k%0d", k), v, 32'((k / 4) % 5));
      if (k == 19 || k == 20) begin
        rd(4'd4, v);
        chk($sformatf("psc ovf k%0d", k), 32'(v[0]), 32'(k == 20));
      end
      @(negedge clk);
    end

    // up/down, TOP=5, CMP1=2, POL1=1
    halt();
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd5);
    wr(4'd6, 32'd2);
    rd(4'd6, v);
    chk("cmp1 readback", v, 32'd2);
    wr(4'd0, 32'h203);
    for (int k = 0; k < 12; k++) begin
      bus.ld = 1'b0;
      m = k % 10;
      rd(4'd3, v);
      chk($sformatf("ud cnt k%0d", k), v, 32'((m <= 5) ? m : 10 - m));
      if (k >= 1) begin
        m  = (k - 1) % 10;
        pc = (m <= 5) ? m : 10 - m;
        chk($sformatf("ud pwm1 k%0d", k), 32'(pwm[1]), 32'(!(pc < 2)));
      end
      rd(4'd4, v);
      if (k == 2 || k == 4 || k == 8)
        chk($sformatf("ud match1 k%0d", k), 32'(v[2]), 32'(k != 4));
      if (k == 9 || k == 10)
        chk($sformatf("ud ovf k%0d", k), 32'(v[0]), 32'(k == 10));
      if (k == 3) begin
        bus.addr = 4'd4;
        bus.d_in = 32'h4;
        bus.ld   = 1'b1;
      end
      @(negedge clk);
    end
    bus.ld = 1'b0;

    // shadowed TOP: write 4 at count 2 while running
    halt();
    wr(4'd1, 32'd9);
    wr(4'd0, 32'h1);
    for (int k = 0; k < 17; k++) begin
      bus.ld = 1'b0;
      rd(4'd3, v);
      chk($sformatf("shd cnt k%0d", k), v, 32'((k <= 9) ? k : ((k <= 14) ? k - 10 : k - 15)));
      if (k == 5) begin
        rd(4'd1, v);
        chk("shd top readback", v, 32'd4);
      end
      if (k == 2) begin
        bus.addr = 4'd1;
        bus.d_in = 32'd4;
        bus.ld   = 1'b1;
      end
      @(negedge clk);
    end
    bus.ld = 1'b0;

    // TOP write while stopped takes effect without an update event
    halt();
    wr(4'd1, 32'd9);
    wr(4'd3, 32'd5);
    wr(4'd0, 32'h1);
    for (int k = 0; k < 6; k++) begin
      rd(4'd3, v);
      chk($sformatf("stop-top cnt k%0d", k), v, 32'((k < 5) ? 5 + k : 0));
      if (k >= 4) begin
        rd(4'd4, v);
        chk($sformatf("stop-top ovf k%0d", k), 32'(v[0]), 32'(k == 5));
      end
      @(negedge clk);
    end

    // CMP0=0 -> always inactive; CMP0=12 > TOP -> always active
    halt();
    wr(4'd5, 32'd0);
    wr(4'd0, 32'h1);
    for (int k = 0; k < 12; k++) begin
      if (k >= 1) chk($sformatf("cmp0=0 pwm0 k%0d", k), 32'(pwm[0]), 32'h0);
      @(negedge clk);
    end
    halt();
    wr(4'd5, 32'd12);
    wr(4'd0, 32'h1);
    for (int k = 0; k < 12; k++) begin
      if (k >= 1) chk($sformatf("cmp0=12 pwm0 k%0d", k), 32'(pwm[0]), 32'h1);
      @(negedge clk);
    end

    // TOP=0: OVF on every tick; W1C colliding with the set leaves OVF at 1
    halt();
    wr(4'd1, 32'd0);
    wr(4'd0, 32'h9);
    for (int k = 0; k < 7; k++) begin
      bus.ld = 1'b0;
      rd(4'd3, v);
      chk($sformatf("top0 cnt k%0d", k), v, 32'h0);
      rd(4'd4, v);
      chk($sformatf("top0 ovf k%0d", k), 32'(v[0]), 32'(k >= 1));
      chk($sformatf("top0 ovf_irq k%0d", k), 32'(ovf_irq), 32'(k >= 1));
      if (k < 6) begin
        bus.addr = 4'd4;
        bus.d_in = 32'h1;
        bus.ld   = 1'b1;
      end
      @(negedge clk);
    end
    bus.ld = 1'b0;
    wr(4'd0, 32'h0);
    wr(4'd4, 32'h1);
    rd(4'd4, v);
    chk("w1c stopped ovf", 32'(v[0]), 32'h0);

    // ext_in source, period 7 clk, 3-cycle edge-to-count latency
    halt();
    wr(4'd1, 32'd100);
    wr(4'd0, 32'hF25);
    rd(4'd0, v);
    chk("ctrl readback", v, 32'hF25);
    for (int k = 0; k < 35; k++) begin
      rd(4'd3, v);
      chk($sformatf("ext cnt k%0d", k), v, 32'((k >= 3) ? (k - 3) / 7 + 1 : 0));
      #1;
      if (k % 7 == 0) ext_in = 1'b1;
      else if (k % 7 == 3) ext_in = 1'b0;
      @(negedge clk);
    end
    chk("ext pwm inverted", 32'(pwm), 32'hE);
    rd(4'd4, v);
    chk("ext status", v, 32'h4);
    chk("ext match_irq", 32'(match_irq), 32'h1);

    // async reset mid-cycle
    #2 rst = 1'b0;
    #1;
    chk("arst pwm", 32'(pwm), 32'h0);
    chk("arst irqs", {30'b0, ovf_irq, match_irq}, 32'h0);
    rd(4'd3, v);
    chk("arst cnt", v, 32'h0);
    rd(4'd4, v);
    chk("arst status", v, 32'h0);
    rd(4'd0, v);
    chk("arst ctrl", v, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
